// File: rtl/mem_stage_if.sv
// EX->MEM, SRAM response and MEM->WB signal bundle for mem_stage.
// master = surrounding pipeline/SRAM side, slave = the MEM stage itself.
interface mem_stage_if #(
  parameter int MS2WS_LEN = 150
);
  logic                 es2ms_valid;
  logic                 ms_allowin;
  logic [MS2WS_LEN-1:0] es2ms_bus;
  logic [38:0]          es_rf_zip;
  logic [4:0]           es_ld_op;
  logic                 es_mem_req;
  logic                 data_sram_data_ok;
  logic [31:0]          data_sram_rdata;
  logic                 ws_allowin;
  logic                 ms2ws_valid;
  logic [MS2WS_LEN-1:0] ms2ws_bus;
  logic [38:0]          ms_rf_zip;

  modport master (
    output es2ms_valid, es2ms_bus, es_rf_zip, es_ld_op, es_mem_req,
    output data_sram_data_ok, data_sram_rdata, ws_allowin,
    input  ms_allowin, ms2ws_valid, ms2ws_bus, ms_rf_zip
  );

  modport slave (
    input  es2ms_valid, es2ms_bus, es_rf_zip, es_ld_op, es_mem_req,
    input  data_sram_data_ok, data_sram_rdata, ws_allowin,
    output ms_allowin, ms2ws_valid, ms2ws_bus, ms_rf_zip
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: waits for the data-SRAM response, aligns/extends load data, passes the CSR/exception bus to WB.
// Optional feature macro MS_LOAD_FWD_EN: loads drive the ID bypass in their data_ok cycle.
module mem_stage #(
  parameter int MS2WS_LEN = 150,
  parameter int CANCEL_W  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  mem_stage_if.slave  bus,
  output logic        ms_ex,
  output logic [38:0] ms_fwd_zip
);
  logic                 ms_valid;
  logic [MS2WS_LEN-1:0] bus_r;
  logic [38:0]          rf_zip_r;
  logic [4:0]           ld_op_r;
  logic                 mem_req_r;
  logic [31:0]          rdata_buf;
  logic                 rdata_buf_v;
  logic [CANCEL_W-1:0]  cancel_cnt;
  logic [CANCEL_W-1:0]  cancel_nxt;
  logic [CANCEL_W+1:0]  cancel_sum;
  logic [1:0]           cancel_inc;
  logic                 cancel_dec;
  logic                 cancel_zero;
  logic                 resp_take;
  logic                 wait_data;
  logic                 ms_ready_go;
  logic                 leave;
  logic                 is_load;
  logic                 fwd_valid;
  logic                 rf_we;
  logic [31:0]          vaddr;
  logic [31:0]          raw;
  logic [31:0]          final_wdata;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;

  assign vaddr       = bus_r[MS2WS_LEN-1 -: 32];
  assign cancel_zero = (cancel_cnt == '0);
  assign resp_take   = bus.data_sram_data_ok & cancel_zero;
  assign wait_data   = ms_valid & mem_req_r & ~rdata_buf_v;
  assign ms_ready_go = ~wait_data | resp_take;
  assign leave       = bus.ms2ws_valid & bus.ws_allowin;
  assign rf_we       = rf_zip_r[37] & ms_valid;
  assign is_load     = |ld_op_r;

  assign bus.ms_allowin  = ~ms_valid | (ms_ready_go & bus.ws_allowin);
  assign bus.ms2ws_valid = ms_valid & ms_ready_go & ~flush;
  assign bus.ms2ws_bus   = bus_r;
  assign bus.ms_rf_zip   = {rf_zip_r[38], rf_we, rf_zip_r[36:32], final_wdata};
  assign ms_ex           = ms_valid & (|bus_r[6:0]);

  always_comb begin
    raw = rdata_buf_v ? rdata_buf : bus.data_sram_rdata;
    unique case (vaddr[1:0])
      2'd0:    ld_byte = raw[7:0];
      2'd1:    ld_byte = raw[15:8];
      2'd2:    ld_byte = raw[23:16];
      default: ld_byte = raw[31:24];
    endcase
    ld_half = vaddr[1] ? raw[31:16] : raw[15:0];
    final_wdata = rf_zip_r[31:0];
    if (ld_op_r[0])      final_wdata = {{24{ld_byte[7]}}, ld_byte};
    else if (ld_op_r[1]) final_wdata = {24'h0, ld_byte};
    else if (ld_op_r[2]) final_wdata = {{16{ld_half[15]}}, ld_half};
    else if (ld_op_r[3]) final_wdata = {16'h0, ld_half};
    else if (ld_op_r[4]) final_wdata = raw;
  end

`ifdef MS_LOAD_FWD_EN
  assign fwd_valid = rf_we & (~is_load | ms_ready_go);
`else
  assign fwd_valid = rf_we & ~is_load;
`endif
  assign ms_fwd_zip = {fwd_valid, rf_we, rf_zip_r[36:32], final_wdata};

  // Flush may orphan both the response MEM waits on and one EX has already requested,
  // so up to two increments can land in one cycle alongside a decrement.
  always_comb begin
    cancel_inc = {1'b0, flush & wait_data & ~resp_take}
               + {1'b0, flush & bus.es2ms_valid & bus.es_mem_req};
    cancel_dec = bus.data_sram_data_ok & ~cancel_zero;
    cancel_sum = {2'b00, cancel_cnt} + {{CANCEL_W{1'b0}}, cancel_inc}
               - {{(CANCEL_W+1){1'b0}}, cancel_dec};
    if (cancel_sum > {2'b00, {CANCEL_W{1'b1}}}) cancel_nxt = '1;
    else                                          cancel_nxt = cancel_sum[CANCEL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid    <= 1'b0;
      bus_r       <= '0;
      rf_zip_r    <= '0;
      ld_op_r     <= '0;
      mem_req_r   <= 1'b0;
      rdata_buf   <= '0;
      rdata_buf_v <= 1'b0;
      cancel_cnt  <= '0;
    end else begin
      if (flush)               ms_valid <= 1'b0;
      else if (bus.ms_allowin) ms_valid <= bus.es2ms_valid;

      if (bus.es2ms_valid && bus.ms_allowin) begin
        bus_r     <= bus.es2ms_bus;
        rf_zip_r  <= bus.es_rf_zip;
        ld_op_r   <= bus.es_ld_op;
        mem_req_r <= bus.es_mem_req;
      end

      if (flush || leave) begin
        rdata_buf_v <= 1'b0;
      end else if (wait_data && resp_take && !bus.ws_allowin) begin
        rdata_buf_v <= 1'b1;
        rdata_buf   <= bus.data_sram_rdata;
      end

      cancel_cnt <= cancel_nxt;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed cases, then randomized traffic against a reference model.
module tb_mem_stage;
  localparam int LEN = 150;

  typedef struct {
    int          dly;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    logic [LEN-1:0] bus;
    logic [38:0]    rf;
    logic           ex;
    logic [38:0]    fwd;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic flush = 1'b0;
  logic ms_ex;
  logic [38:0] ms_fwd_zip;

  int vectors = 0;
  int miscompares = 0;
  exp_t  exp_q[$];
  resp_t resp_q[$];
  bit    ws_rand = 1'b0;
  logic  ws_force = 1'b1;

  mem_stage_if #(.MS2WS_LEN(LEN)) bus_if ();

  mem_stage #(.MS2WS_LEN(LEN), .CANCEL_W(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .bus        (bus_if.slave),
    .ms_ex      (ms_ex),
    .ms_fwd_zip (ms_fwd_zip)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [LEN-1:0] act, input logic [LEN-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: shift the addressed byte/half down, then extend by load kind.
  function automatic logic [31:0] load_val(input logic [4:0] op, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] s;
    s = w >> (32'(off) * 8);
    case (op)
      5'b00001: return {{24{s[7]}}, s[7:0]};
      5'b00010: return {24'h0, s[7:0]};
      5'b00100: return {{16{s[15]}}, s[15:0]};
      5'b01000: return {16'h0, s[15:0]};
      default:  return w;
    endcase
  endfunction

  task automatic send(input logic [31:0] vaddr, input logic [6:0] exc, input logic [4:0] op,
                      input logic mreq, input logic [31:0] alu, input logic [31:0] rdata,
                      input int dly, input bit track);
    logic [95:0]    r96;
    logic [LEN-1:0] b;
    logic [38:0]    rz;
    logic [31:0]    wd;
    logic           fv;
    exp_t           e;
    int             guard;
    r96 = {$urandom, $urandom, $urandom};
    b   = {vaddr, 32'($urandom), r96[78:0], exc};
    rz  = {1'($urandom), 1'($urandom), 5'($urandom), alu};
    bus_if.es2ms_valid = 1'b1;
    bus_if.es2ms_bus   = b;
    bus_if.es_rf_zip   = rz;
    bus_if.es_ld_op    = op;
    bus_if.es_mem_req  = mreq;
    guard = 0;
    @(negedge clk);
    while (!bus_if.ms_allowin && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) check("accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    bus_if.es2ms_valid = 1'b0;
    bus_if.es_mem_req  = 1'b0;
    if (track) begin
      wd = (op != 5'b0) ? load_val(op, vaddr[1:0], rdata) : alu;
`ifdef MS_LOAD_FWD_EN
      fv = rz[37];
`else
      fv = rz[37] & (op == 5'b0);
`endif
      e.bus = b;
      e.rf  = {rz[38], rz[37], rz[36:32], wd};
      e.ex  = |exc;
      e.fwd = {fv, rz[37], rz[36:32], wd};
      exp_q.push_back(e);
    end
    if (dly >= 0) resp_q.push_back('{dly, rdata});
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  // Shared tail of the flush cases: one stale response must be swallowed, then the real one retires.
  task automatic stale_then_real(input logic [31:0] real_data);
    @(negedge clk);
    check("flush_ms2ws_valid", bus_if.ms2ws_valid, 1'b0);
    check("flush_ms_allowin", bus_if.ms_allowin, 1'b1);
    @(posedge clk);
    #1;
    resp_q.push_back('{1, 32'h0000_DEAD});
    send(32'h0000_1000, 7'd0, 5'b10000, 1'b1, 32'h0, real_data, 0, 1'b1);
    @(negedge clk);
    check("stale_dropped", bus_if.ms2ws_valid, 1'b0);
    drain();
  endtask

  initial begin : responder
    resp_t cur;
    bit    busy = 1'b0;
    bus_if.data_sram_data_ok = 1'b0;
    bus_if.data_sram_rdata   = '0;
    forever begin
      @(posedge clk);
      #2;
      bus_if.data_sram_data_ok = 1'b0;
      bus_if.data_sram_rdata   = $urandom;
      if (!busy && resp_q.size() != 0) begin
        cur  = resp_q.pop_front();
        busy = 1'b1;
      end
      if (busy) begin
        if (cur.dly <= 0) begin
          bus_if.data_sram_data_ok = 1'b1;
          bus_if.data_sram_rdata   = cur.rdata;
          busy = 1'b0;
        end else begin
          cur.dly--;
        end
      end
    end
  end

  initial begin : ws_drive
    bus_if.ws_allowin = 1'b1;
    forever begin
      @(posedge clk);
      #3;
      bus_if.ws_allowin = ws_rand ? ($urandom_range(0, 3) != 0) : ws_force;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn && bus_if.ms2ws_valid && bus_if.ws_allowin) begin
      if (exp_q.size() == 0) begin
        check("unexpected_retire", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("ms2ws_bus", bus_if.ms2ws_bus, e.bus);
        check("ms_rf_zip", bus_if.ms_rf_zip, e.rf);
        check("ms_ex", ms_ex, e.ex);
        check("ms_fwd_zip", ms_fwd_zip, e.fwd);
      end
    end
  end

  initial begin : main
    logic [31:0] va;
    logic [4:0]  op;
    int          kind;
    int          opi;
    bus_if.es2ms_valid = 1'b0;
    bus_if.es2ms_bus   = '0;
    bus_if.es_rf_zip   = '0;
    bus_if.es_ld_op    = '0;
    bus_if.es_mem_req  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rst_ms2ws_valid", bus_if.ms2ws_valid, 1'b0);
    check("rst_ms_ex", ms_ex, 1'b0);
    check("rst_fwd_valid", ms_fwd_zip[38], 1'b0);
    check("rst_ms_allowin", bus_if.ms_allowin, 1'b1);
    @(posedge clk);
    #1;

    // ALU op: one-cycle latency
    send(32'h0, 7'd0, 5'b0, 1'b0, 32'h0000_1234, 32'h0, -1, 1'b1);
    @(negedge clk);
    check("alu_latency", bus_if.ms2ws_valid, 1'b1);
    drain();

    // ld_b on byte 3, response three cycles late
    send(32'h0000_2003, 7'd0, 5'b00001, 1'b1, 32'h0, 32'h80FF_0000, 3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ld_b_stall", bus_if.ms2ws_valid, 1'b0);
    end
    drain();

    send(32'h0000_3002, 7'd0, 5'b01000, 1'b1, 32'h0, 32'h8001_7FFF, 0, 1'b1);
    drain();
    send(32'h0000_3002, 7'd0, 5'b00100, 1'b1, 32'h0, 32'h8001_7FFF, 0, 1'b1);
    drain();

    // Flush while a load waits, stale response then the real one
    send(32'h0000_4000, 7'd0, 5'b10000, 1'b1, 32'h0, 32'h0, -1, 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    stale_then_real(32'h0000_0042);

    // Flush orphaning a request EX has already issued
    bus_if.es2ms_valid = 1'b1;
    bus_if.es_mem_req  = 1'b1;
    bus_if.es_ld_op    = 5'b10000;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus_if.es2ms_valid = 1'b0;
    bus_if.es_mem_req  = 1'b0;
    stale_then_real(32'h1357_9BDF);

    // Response buffered while WB stalls
    ws_force = 1'b0;
    @(posedge clk);
    #1;
    send(32'h0000_5000, 7'd0, 5'b10000, 1'b1, 32'h0, 32'hCAFE_BABE, 0, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("buffered_valid", bus_if.ms2ws_valid, 1'b1);
    @(posedge clk);
    #1;
    ws_force = 1'b1;
    drain();

    // Exception instruction: no SRAM wait, ms_ex raised
    send(32'h0000_6000, 7'b0000010, 5'b0, 1'b0, 32'h0000_00AA, 32'h0, -1, 1'b1);
    @(negedge clk);
    check("sys_ms_ex", ms_ex, 1'b1);
    drain();

    ws_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      va   = $urandom;
      if (kind <= 2) begin
        send(va, 7'd0, 5'b0, 1'b0, $urandom, 32'h0, -1, 1'b1);
      end else if (kind <= 6) begin
        opi = $urandom_range(0, 4);
        op  = 5'b00001 << opi;
        if (opi == 4) va[1:0] = 2'b00;
        else if (opi >= 2) va[0] = 1'b0;
        send(va, 7'd0, op, 1'b1, $urandom, $urandom, $urandom_range(0, 3), 1'b1);
      end else if (kind <= 8) begin
        send(va, 7'd0, 5'b0, 1'b1, $urandom, $urandom, $urandom_range(0, 3), 1'b1);
      end else begin
        send(va, 7'($urandom_range(1, 127)), 5'b0, 1'b0, $urandom, 32'h0, -1, 1'b1);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
